// File: rtl/bus_dma_initiator_pkg.sv
// Femto bus shared definitions plus element-size helpers for the DMA initiator.
// Pure declarations: no logic, no latency.
`ifndef FEMTO_VH
`define FEMTO_VH
`define BUS_WIDTH      32
`define BUS_ACC_WIDTH  2
`define BUS_ACC_1B     2'd0
`define BUS_ACC_2B     2'd1
`define BUS_ACC_4B     2'd2
`define DMA_ERR_NONE     2'd0
`define DMA_ERR_MISALIGN 2'd1
`define DMA_ERR_FAULT    2'd2
`define DMA_ERR_TIMEOUT  2'd3
`endif

package bus_dma_initiator_pkg;

  localparam int BUS_W = `BUS_WIDTH;
  localparam int ACC_W = `BUS_ACC_WIDTH;

  localparam logic [ACC_W-1:0] ACC_1B = `BUS_ACC_1B;
  localparam logic [ACC_W-1:0] ACC_2B = `BUS_ACC_2B;
  localparam logic [ACC_W-1:0] ACC_4B = `BUS_ACC_4B;

  localparam logic [1:0] ERR_NONE     = `DMA_ERR_NONE;
  localparam logic [1:0] ERR_MISALIGN = `DMA_ERR_MISALIGN;
  localparam logic [1:0] ERR_FAULT    = `DMA_ERR_FAULT;
  localparam logic [1:0] ERR_TIMEOUT  = `DMA_ERR_TIMEOUT;

  // Unknown size codes are treated as full words.
  function automatic logic [2:0] acc_bytes(input logic [ACC_W-1:0] acc);
    case (acc)
      ACC_1B:  return 3'd1;
      ACC_2B:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [BUS_W-1:0] lane_mask(input logic [ACC_W-1:0] acc);
    case (acc)
      ACC_1B:  return BUS_W'(8'hFF);
      ACC_2B:  return BUS_W'(16'hFFFF);
      default: return '1;
    endcase
  endfunction

endpackage

// File: rtl/bus_dma_initiator.sv
// Memory-to-memory copy engine mastering the femto bus: one read then one write per element.
// 4 cycles/element with a 1-cycle responder; waits on bus_resp with a timeout, abort stops at element boundary.
module bus_dma_initiator
  import bus_dma_initiator_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [ACC_W-1:0]      acc,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_w_rb,
  output logic [ACC_W-1:0]      bus_acc,
  output logic [BUS_W-1:0]      bus_wdata,
  output logic                  bus_req,
  input  logic [BUS_W-1:0]      bus_rdata,
  input  logic                  bus_resp,
  input  logic                  bus_fault
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CHECK, ST_RD_REQ, ST_RD_WAIT, ST_WR_REQ, ST_WR_WAIT, ST_FIN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_src_q, cur_src_d;
  logic [ADDR_WIDTH-1:0] cur_dst_q, cur_dst_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic                  abort_q, abort_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic                  bus_w_rb_q, bus_w_rb_d;
  logic [BUS_W-1:0]      bus_wdata_q, bus_wdata_d;
  logic                  bus_req_q, bus_req_d;

  logic [2:0]            size;
  logic                  misaligned;
  logic                  tmo_hit;
  logic [LEN_WIDTH-1:0]  rem_next;

  assign size       = acc_bytes(acc_q);
  assign misaligned = ((cur_src_q & ADDR_WIDTH'(size - 3'd1)) != '0) ||
                      ((cur_dst_q & ADDR_WIDTH'(size - 3'd1)) != '0) ||
                      ((rem_q     & LEN_WIDTH'(size - 3'd1))  != '0);
  assign tmo_hit    = (tmo_q == TW'(TIMEOUT - 1));
  assign rem_next   = rem_q - LEN_WIDTH'(size);

  always_comb begin
    state_d     = state_q;
    cur_src_d   = cur_src_q;
    cur_dst_d   = cur_dst_q;
    rem_d       = rem_q;
    acc_d       = acc_q;
    abort_d     = abort_q | (busy_q & abort);
    tmo_d       = tmo_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    aborted_d   = aborted_q;
    err_code_d  = err_code_q;
    err_addr_d  = err_addr_q;
    bus_addr_d  = bus_addr_q;
    bus_w_rb_d  = bus_w_rb_q;
    bus_wdata_d = bus_wdata_q;
    bus_req_d   = 1'b0;

    // Every path into FIN raises done and drops busy on the same edge.
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_CHECK;
          busy_d     = 1'b1;
          cur_src_d  = src;
          cur_dst_d  = dst;
          rem_d      = len;
          acc_d      = acc;
          abort_d    = 1'b0;
          aborted_d  = 1'b0;
          err_code_d = ERR_NONE;
          err_addr_d = '0;
        end
      end
      ST_CHECK: begin
        if (misaligned || rem_q == '0) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          if (misaligned) begin
            err_code_d = ERR_MISALIGN;
            err_addr_d = cur_src_q;
          end
        end else begin
          state_d    = ST_RD_REQ;
          bus_req_d  = 1'b1;
          bus_w_rb_d = 1'b0;
          bus_addr_d = cur_src_q;
        end
      end
      ST_RD_REQ, ST_WR_REQ: begin
        if (bus_fault) begin
          state_d    = ST_FIN;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          err_code_d = ERR_FAULT;
          err_addr_d = bus_addr_q;
        end else begin
          state_d = (state_q == ST_RD_REQ) ? ST_RD_WAIT : ST_WR_WAIT;
          tmo_d   = '0;
        end
      end
      ST_RD_WAIT: begin
        if (bus_resp) begin
          state_d     = ST_WR_REQ;
          bus_wdata_d = bus_rdata & lane_mask(acc_q);
          bus_req_d   = 1'b1;
          bus_w_rb_d  = 1'b1;
          bus_addr_d  = cur_dst_q;
        end else if (tmo_hit) begin
          state_d    = ST_FIN;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          err_code_d = ERR_TIMEOUT;
          err_addr_d = bus_addr_q;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_WR_WAIT: begin
        if (bus_resp) begin
          cur_src_d = cur_src_q + ADDR_WIDTH'(size);
          cur_dst_d = cur_dst_q + ADDR_WIDTH'(size);
          rem_d     = rem_next;
          if (rem_next == '0 || abort_d) begin
            state_d   = ST_FIN;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            aborted_d = (rem_next != '0);
          end else begin
            state_d    = ST_RD_REQ;
            bus_req_d  = 1'b1;
            bus_w_rb_d = 1'b0;
            bus_addr_d = cur_src_d;
          end
        end else if (tmo_hit) begin
          state_d    = ST_FIN;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          err_code_d = ERR_TIMEOUT;
          err_addr_d = bus_addr_q;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_src_q   <= '0;
      cur_dst_q   <= '0;
      rem_q       <= '0;
      acc_q       <= ACC_1B;
      abort_q     <= 1'b0;
      tmo_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_addr_q  <= '0;
      bus_addr_q  <= '0;
      bus_w_rb_q  <= 1'b0;
      bus_wdata_q <= '0;
      bus_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_src_q   <= cur_src_d;
      cur_dst_q   <= cur_dst_d;
      rem_q       <= rem_d;
      acc_q       <= acc_d;
      abort_q     <= abort_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      err_code_q  <= err_code_d;
      err_addr_q  <= err_addr_d;
      bus_addr_q  <= bus_addr_d;
      bus_w_rb_q  <= bus_w_rb_d;
      bus_wdata_q <= bus_wdata_d;
      bus_req_q   <= bus_req_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign err_code  = err_code_q;
  assign err_addr  = err_addr_q;
  assign bus_addr  = bus_addr_q;
  assign bus_w_rb  = bus_w_rb_q;
  assign bus_acc   = acc_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_req   = bus_req_q;

endmodule

// File: tb/tb_bus_dma_initiator.sv
// Bench for bus_dma_initiator: byte-array responder on the bus, element-by-element copy model,
// directed cases for faults/timeouts/abort/reset plus randomized transfers.
module tb_bus_dma_initiator;
  import bus_dma_initiator_pkg::*;

  localparam int AW  = 32;
  localparam int LW  = 16;
  localparam int TMO = 8;

  logic             clk = 1'b0;
  logic             rst, start, abort;
  logic [AW-1:0]    src, dst;
  logic [LW-1:0]    len;
  logic [ACC_W-1:0] acc;
  logic             busy, done, aborted;
  logic [1:0]       err_code;
  logic [AW-1:0]    err_addr, bus_addr;
  logic             bus_w_rb;
  logic [ACC_W-1:0] bus_acc;
  logic [BUS_W-1:0] bus_wdata;
  logic             bus_req;
  logic [BUS_W-1:0] bus_rdata = '0;
  logic             bus_resp  = 1'b0;
  logic             bus_fault;

  int checks = 0;
  int errors = 0;

  bus_dma_initiator #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len), .acc(acc),
    .abort(abort), .busy(busy), .done(done), .aborted(aborted), .err_code(err_code),
    .err_addr(err_addr), .bus_addr(bus_addr), .bus_w_rb(bus_w_rb), .bus_acc(bus_acc),
    .bus_wdata(bus_wdata), .bus_req(bus_req), .bus_rdata(bus_rdata), .bus_resp(bus_resp),
    .bus_fault(bus_fault)
  );

  always #5 clk = ~clk;

  // Responder: 256-byte memory aliased over the address space.
  logic [7:0]    mem [256];
  int            resp_delay = 0;   // extra cycles before resp; negative = never respond
  bit            rand_delay = 1'b0;
  bit            fault_en   = 1'b0;
  logic [AW-1:0] fault_addr = '0;
  bit            pend = 1'b0;
  int            pend_cnt = 0;
  logic [AW-1:0] pend_addr;
  logic [ACC_W-1:0] pend_acc;
  logic [31:0]   rd_word;
  int            req_cnt = 0;
  int            rd_cnt  = 0;
  logic [AW-1:0] log_addr [$];
  bit            log_w    [$];
  logic [31:0]   log_data [$];

  assign bus_fault = fault_en && bus_req && bus_w_rb && (bus_addr == fault_addr);

  function automatic int nbytes(input logic [ACC_W-1:0] a);
    return (a == ACC_1B) ? 1 : (a == ACC_2B) ? 2 : 4;
  endfunction

  always @(negedge clk) begin
    bus_resp = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        rd_word = $urandom;   // unused lanes carry junk the DUT must drop
        for (int b = 0; b < nbytes(pend_acc); b++)
          rd_word[8*b +: 8] = mem[8'(pend_addr + 32'(b))];
        bus_rdata = rd_word;
        bus_resp  = 1'b1;
        pend      = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    if (bus_req) begin
      req_cnt++;
      if (!bus_w_rb) rd_cnt++;
      if (!bus_fault) begin
        log_addr.push_back(bus_addr);
        log_w.push_back(bus_w_rb);
        log_data.push_back(bus_w_rb ? bus_wdata : 32'h0);
        if (bus_w_rb)
          for (int b = 0; b < nbytes(bus_acc); b++)
            mem[8'(bus_addr + 32'(b))] = bus_wdata[8*b +: 8];
        if (resp_delay >= 0) begin
          pend      = 1'b1;
          pend_cnt  = rand_delay ? $urandom_range(0, 3) : resp_delay;
          pend_addr = bus_addr;
          pend_acc  = bus_acc;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // exp_nacc: accepted accesses (alternating read/write per element); exp_nreq includes faulted ones.
  // exp_cyc: cycles from busy rising to done (-1 = don't care). abort_at_rd: pulse abort in the
  // wait cycle after that many reads were issued (0 = never).
  task automatic do_xfer(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input int l, input logic [ACC_W-1:0] a, input int exp_nacc,
                         input int exp_nreq, input logic [1:0] exp_err,
                         input logic [AW-1:0] exp_eaddr, input bit exp_ab, input int exp_cyc,
                         input int abort_at_rd, input bit abort_with_start);
    logic [7:0]    model [256];
    logic [AW-1:0] e_addr [$];
    bit            e_w    [$];
    logic [31:0]   e_data [$];
    logic [AW-1:0] sa, da;
    logic [31:0]   w;
    int sz, cyc, ph, bad, el;
    bit got;
    sz = nbytes(a);
    for (int i = 0; i < 256; i++) model[i] = mem[i];
    for (int k = 0; k < exp_nacc; k++) begin
      el = k / 2;
      sa = s + AW'(el * sz);
      da = d + AW'(el * sz);
      if (k % 2 == 0) begin
        e_addr.push_back(sa); e_w.push_back(1'b0); e_data.push_back(32'h0);
      end else begin
        w = '0;
        for (int b = 0; b < sz; b++) w[8*b +: 8] = model[8'(sa + 32'(b))];
        for (int b = 0; b < sz; b++) model[8'(da + 32'(b))] = w[8*b +: 8];
        e_addr.push_back(da); e_w.push_back(1'b1); e_data.push_back(w);
      end
    end
    log_addr.delete(); log_w.delete(); log_data.delete();
    req_cnt = 0; rd_cnt = 0;

    @(negedge clk); #1;
    src = s; dst = d; len = LW'(l); acc = a; start = 1'b1; abort = abort_with_start;
    @(negedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check({tag, " busy_rise"}, busy, 1);
    cyc = 0; got = 1'b0; ph = 0;
    while (!got && cyc < 400) begin
      @(negedge clk); #1;
      cyc++;
      case (ph)
        0: if (abort_at_rd > 0 && rd_cnt == abort_at_rd) ph = 1;
        1: begin abort = 1'b1; ph = 2; end
        2: begin abort = 1'b0; ph = 3; end
        default: ;
      endcase
      if (done) got = 1'b1;
    end
    abort = 1'b0;
    check({tag, " done_seen"}, got, 1);
    check({tag, " busy_at_done"}, busy, 0);
    if (exp_cyc >= 0) check({tag, " cycles"}, cyc, exp_cyc);
    check({tag, " err_code"}, err_code, exp_err);
    check({tag, " err_addr"}, err_addr, exp_eaddr);
    check({tag, " aborted"}, aborted, exp_ab);
    check({tag, " req_cnt"}, req_cnt, exp_nreq);
    check({tag, " n_acc"}, log_addr.size(), exp_nacc);
    for (int k = 0; k < exp_nacc && k < log_addr.size(); k++) begin
      check($sformatf("%s acc%0d addr", tag, k), log_addr[k], e_addr[k]);
      check($sformatf("%s acc%0d w_rb", tag, k), log_w[k], e_w[k]);
      if (e_w[k]) check($sformatf("%s acc%0d wdata", tag, k), log_data[k], e_data[k]);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== model[i]) bad++;
    check({tag, " mem_bytes_wrong"}, bad, 0);
    @(negedge clk); #1;
    check({tag, " done_pulse_1cyc"}, done, 0);
    check({tag, " err_sticky"}, err_code, exp_err);
  endtask

  initial begin
    int n0;
    bit idle_ok;
    rst = 1'b1; start = 1'b0; abort = 1'b0; src = '0; dst = '0; len = '0; acc = ACC_4B;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    repeat (3) @(negedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst aborted", aborted, 0);
    check("rst err_code", err_code, ERR_NONE);
    check("rst err_addr", err_addr, 0);
    check("rst bus_req", bus_req, 0);
    check("rst bus_addr", bus_addr, 0);
    check("rst bus_wdata", bus_wdata, 0);
    rst = 1'b0;

    // Word copy: CHECK cycle, then 4 cycles per element, done on the following cycle.
    do_xfer("t1_word", 32'h00, 32'h40, 16, ACC_4B, 8, 8, ERR_NONE, 0, 0, 1 + 16, 0, 0);
    // Byte copy, odd addresses; abort together with start is ignored.
    do_xfer("t2_byte", 32'h01, 32'h23, 3, ACC_1B, 6, 6, ERR_NONE, 0, 0, 1 + 12, 0, 1);
    do_xfer("t2_half", 32'h10, 32'h82, 6, ACC_2B, 6, 6, ERR_NONE, 0, 0, 1 + 12, 0, 0);
    // Misalignment of src, dst or len: no traffic, err_addr is src.
    do_xfer("t3_src", 32'h02, 32'h40, 8, ACC_4B, 0, 0, ERR_MISALIGN, 32'h02, 0, 1, 0, 0);
    do_xfer("t3_dst", 32'h00, 32'h41, 4, ACC_2B, 0, 0, ERR_MISALIGN, 32'h00, 0, 1, 0, 0);
    do_xfer("t3_len", 32'h04, 32'h40, 6, ACC_4B, 0, 0, ERR_MISALIGN, 32'h04, 0, 1, 0, 0);
    // Write to 0x48 rejected on the 3rd element: 2 full elements + one read accepted.
    fault_en = 1'b1; fault_addr = 32'h48;
    do_xfer("t4_fault", 32'h00, 32'h40, 16, ACC_4B, 5, 6, ERR_FAULT, 32'h48, 0, 12, 0, 0);
    fault_en = 1'b0;
    // Silent responder: CHECK, RD_REQ, TIMEOUT wait cycles, then done.
    resp_delay = -1;
    do_xfer("t5_tmo", 32'h10, 32'h40, 4, ACC_4B, 1, 1, ERR_TIMEOUT, 32'h10, 0, 2 + TMO, 0, 0);
    resp_delay = 0;
    do_xfer("t5_len0", 32'h00, 32'h40, 0, ACC_4B, 0, 0, ERR_NONE, 0, 0, 1, 0, 0);
    // Abort in the 2nd element's read wait: that element finishes, 2 of 4 copied.
    do_xfer("t6_abort", 32'h00, 32'h40, 16, ACC_4B, 4, 4, ERR_NONE, 0, 1, 1 + 8, 2, 0);
    // Source wraps past the top of the address space.
    do_xfer("t7_wrap", 32'hFFFF_FFF8, 32'h80, 16, ACC_4B, 8, 8, ERR_NONE, 0, 0, 1 + 16, 0, 0);

    rand_delay = 1'b1;
    for (int it = 0; it < 6; it++) begin : rnd
      logic [ACC_W-1:0] a2;
      int sz2, l2;
      logic [AW-1:0] s2, d2;
      a2  = ACC_W'($urandom_range(0, 2));
      sz2 = nbytes(a2);
      l2  = sz2 * $urandom_range(1, 8);
      s2  = AW'(sz2 * $urandom_range(0, 255 / sz2));
      d2  = AW'(sz2 * $urandom_range(0, 255 / sz2));
      do_xfer($sformatf("rnd%0d", it), s2, d2, l2, a2, 2 * (l2 / sz2), 2 * (l2 / sz2),
              ERR_NONE, 0, 0, -1, 0, 0);
    end
    rand_delay = 1'b0;

    // Reset during RD_WAIT; the responder's response lands after reset and must be ignored.
    resp_delay = 2;
    req_cnt = 0; rd_cnt = 0;
    @(negedge clk); #1;
    src = 32'h00; dst = 32'h40; len = 16; acc = ACC_4B; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    n0 = 0;
    while (rd_cnt == 0 && n0 < 20) begin @(negedge clk); #1; n0++; end
    check("t6_rst read_issued", rd_cnt, 1);
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    check("t6_rst busy", busy, 0);
    check("t6_rst done", done, 0);
    check("t6_rst bus_req", bus_req, 0);
    check("t6_rst bus_addr", bus_addr, 0);
    check("t6_rst bus_w_rb", bus_w_rb, 0);
    check("t6_rst bus_wdata", bus_wdata, 0);
    check("t6_rst err_code", err_code, ERR_NONE);
    check("t6_rst err_addr", err_addr, 0);
    idle_ok = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      if (busy || done || bus_req) idle_ok = 1'b0;
    end
    check("t6_rst late_resp_ignored", idle_ok, 1);
    check("t6_rst req_cnt", req_cnt, 1);
    resp_delay = 0;
    do_xfer("t6_after_rst", 32'h20, 32'hC0, 8, ACC_2B, 8, 8, ERR_NONE, 0, 0, 1 + 16, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
